// File: rtl/fault_campaign_ctrl.sv
// ---------------------------------------------------------------------------
// fault_campaign_ctrl
//
// Sequencer for stuck-at fault campaigns. Arms one fault site at a time,
// replays the same pseudo-random vector sequence into a golden and a faulted
// copy of the DUT, compares their outputs every RUN cycle and reports a
// per-fault detect result plus a running count of detected faults.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   start         begin a campaign (only honoured in IDLE)
//   abort         synchronous abort back to IDLE, priority over start
//   fault_en      one-hot stuck-at enable to the faulted DUT, 0 when unarmed
//   vec_out       16-bit LFSR stimulus to both DUT copies
//   golden_y      fault-free DUT output (combinational from vec_out)
//   faulty_y      faulted DUT output (combinational from vec_out)
//   busy          high in every state except IDLE
//   done          one-cycle pulse when the campaign completes
//   det_valid     one-cycle pulse per fault result
//   det_flag      1 = fault det_fault was detected, valid with det_valid
//   det_fault     index of the fault being reported
//   detected_cnt  number of detected faults so far
// ---------------------------------------------------------------------------
module fault_campaign_ctrl #(
  parameter int NFAULTS    = 32,
  parameter int NVEC       = 64,
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1,
  localparam int FW = (NFAULTS > 1) ? $clog2(NFAULTS) : 1,
  localparam int VW = (NVEC > 1) ? $clog2(NVEC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [NFAULTS-1:0] fault_en,
  output logic [15:0]        vec_out,
  input  logic [WIDTH-1:0]   golden_y,
  input  logic [WIDTH-1:0]   faulty_y,
  output logic               busy,
  output logic               done,
  output logic               det_valid,
  output logic               det_flag,
  output logic [FW-1:0]      det_fault,
  output logic [FW:0]        detected_cnt
);

  localparam logic [15:0]        LFSR_SEED = 16'hACE1;
  localparam logic [NFAULTS-1:0] ONE_HOT0  = NFAULTS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_LOG,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [FW-1:0] cur_fault;
  logic [VW-1:0] vcnt;
  logic          det;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic          mismatch;
  logic          run_exit;
  logic          last_vec;
  logic          last_fault;

  // Fibonacci LFSR, taps 16,14,13,11 expressed on a right-shifting register.
  assign lfsr_next  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign last_vec   = (vcnt == VW'(NVEC - 1));
  assign last_fault = (cur_fault == FW'(NFAULTS - 1));

  assign vec_out = lfsr;
  assign busy    = (state != S_IDLE);

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    mismatch   = 1'b0;
    run_exit   = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_ARM;
      S_ARM:  state_next = S_RUN;
      S_RUN: begin
        // Comparison is only meaningful while vectors are being applied.
        mismatch = (golden_y != faulty_y);
        run_exit = last_vec || ((EARLY_EXIT != 0) && mismatch);
        if (run_exit) state_next = S_LOG;
      end
      S_LOG:  state_next = last_fault ? S_DONE : S_ARM;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Outputs are registered and updated on state entry, so fault_en only
  // changes when entering ARM (set) or LOG (cleared) and never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_fault    <= '0;
      vcnt         <= '0;
      det          <= 1'b0;
      lfsr         <= LFSR_SEED;
      fault_en     <= '0;
      done         <= 1'b0;
      det_valid    <= 1'b0;
      det_flag     <= 1'b0;
      det_fault    <= '0;
      detected_cnt <= '0;
    end else if (abort) begin
      // Results in flight are dropped; the count keeps its value.
      fault_en  <= '0;
      done      <= 1'b0;
      det_valid <= 1'b0;
    end else begin
      done      <= 1'b0;
      det_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_fault    <= '0;
            detected_cnt <= '0;
            fault_en     <= ONE_HOT0;
            lfsr         <= LFSR_SEED;
            vcnt         <= '0;
            det          <= 1'b0;
          end
        end
        S_RUN: begin
          lfsr <= lfsr_next;
          vcnt <= vcnt + VW'(1);
          det  <= det | mismatch;
          if (run_exit) begin
            fault_en  <= '0;
            det_valid <= 1'b1;
            // Includes a mismatch seen on this final RUN cycle.
            det_flag  <= det | mismatch;
            det_fault <= cur_fault;
          end
        end
        S_LOG: begin
          detected_cnt <= detected_cnt + {{FW{1'b0}}, det_flag};
          if (last_fault) begin
            done <= 1'b1;
          end else begin
            cur_fault <= cur_fault + FW'(1);
            fault_en  <= ONE_HOT0 << (cur_fault + FW'(1));
            lfsr      <= LFSR_SEED;
            vcnt      <= '0;
            det       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fault_campaign_ctrl
//
// Two controller instances (index 0: early exit, index 1: full run) with
// NFAULTS=4, NVEC=8 share start/abort/reset. Each has its own golden/faulty
// DUT model: golden = vec ^ 16'h3C5A, faulty = golden with bit 0 flipped
// under a mode-selected condition (fault armed and a given vector index).
// ---------------------------------------------------------------------------
module tb_fault_campaign_ctrl;

  localparam int NF = 4;
  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  int          mode = 0;

  logic [3:0]  fault_en     [2];
  logic [15:0] vec_out      [2];
  logic [15:0] golden_y     [2];
  logic [15:0] faulty_y     [2];
  logic        busy         [2];
  logic        done         [2];
  logic        det_valid    [2];
  logic        det_flag     [2];
  logic [1:0]  det_fault    [2];
  logic [2:0]  detected_cnt [2];

  logic [15:0] seq [NV];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fault_campaign_ctrl #(.NFAULTS(NF), .NVEC(NV), .WIDTH(16), .EARLY_EXIT(1)) dut_early (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fault_en(fault_en[0]), .vec_out(vec_out[0]),
    .golden_y(golden_y[0]), .faulty_y(faulty_y[0]),
    .busy(busy[0]), .done(done[0]), .det_valid(det_valid[0]),
    .det_flag(det_flag[0]), .det_fault(det_fault[0]),
    .detected_cnt(detected_cnt[0])
  );

  fault_campaign_ctrl #(.NFAULTS(NF), .NVEC(NV), .WIDTH(16), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fault_en(fault_en[1]), .vec_out(vec_out[1]),
    .golden_y(golden_y[1]), .faulty_y(faulty_y[1]),
    .busy(busy[1]), .done(done[1]), .det_valid(det_valid[1]),
    .det_flag(det_flag[1]), .det_fault(det_fault[1]),
    .detected_cnt(detected_cnt[1])
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Mode 0: no fault visible. Mode 1: fault 2 at vector 5. Mode 2: fault 0
  // at vector 7 (last vector). Vector index is recognised by LFSR value.
  always_comb begin
    logic flip;
    for (int d = 0; d < 2; d++) begin
      flip = 1'b0;
      if (mode == 1) flip = fault_en[d][2] && (vec_out[d] == seq[5]);
      if (mode == 2) flip = fault_en[d][0] && (vec_out[d] == seq[7]);
      golden_y[d] = vec_out[d] ^ 16'h3C5A;
      faulty_y[d] = golden_y[d] ^ {15'd0, flip};
    end
  end

  // ---------------- monitor (samples on falling edge) ----------------
  int          cyc = 0;
  int          run_cnt   [2];
  int          nvalid    [2];
  int          done_seen [2];
  int          arm_cyc   [2];
  int          done_cyc  [2];
  logic        busy_q    [2];
  int          len       [2][NF];
  logic        flg       [2][NF];
  logic [1:0]  fidx      [2][NF];
  logic [15:0] v0        [2][NF];
  logic [15:0] v1        [2][NF];

  task automatic clear_log();
    for (int d = 0; d < 2; d++) begin
      run_cnt[d] = 0; nvalid[d] = 0; done_seen[d] = 0;
      arm_cyc[d] = -1; done_cyc[d] = -1;
      for (int f = 0; f < NF; f++) begin
        len[d][f] = -1; flg[d][f] = 1'bx; fidx[d][f] = 2'bxx;
        v0[d][f] = 16'h0; v1[d][f] = 16'h0;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (busy[d] && !busy_q[d] && arm_cyc[d] < 0) arm_cyc[d] = cyc;
      busy_q[d] = busy[d];
      if (fault_en[d] != 4'b0) begin
        for (int f = 0; f < NF; f++) begin
          if (fault_en[d][f]) begin
            if (run_cnt[d] == 1) v0[d][f] = vec_out[d];
            if (run_cnt[d] == 2) v1[d][f] = vec_out[d];
          end
        end
        run_cnt[d] = run_cnt[d] + 1;
      end else begin
        if (det_valid[d]) begin
          if (nvalid[d] < NF) begin
            fidx[d][nvalid[d]] = det_fault[d];
            flg[d][nvalid[d]]  = det_flag[d];
            len[d][det_fault[d]] = run_cnt[d] - 1;  // minus the ARM cycle
          end
          nvalid[d] = nvalid[d] + 1;
        end
        run_cnt[d] = 0;
      end
      if (done[d]) begin
        done_seen[d] = done_seen[d] + 1;
        done_cyc[d]  = cyc;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_fault_en"},  32'(fault_en[d]),     32'h0);
      check({tag, "_vec_out"},   32'(vec_out[d]),      32'hACE1);
      check({tag, "_busy"},      32'(busy[d]),         32'h0);
      check({tag, "_done"},      32'(done[d]),         32'h0);
      check({tag, "_det_valid"}, 32'(det_valid[d]),    32'h0);
      check({tag, "_det_flag"},  32'(det_flag[d]),     32'h0);
      check({tag, "_det_fault"}, 32'(det_fault[d]),    32'h0);
      check({tag, "_cnt"},       32'(detected_cnt[d]), 32'h0);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_campaign(input int m);
    int budget;
    clear_log();
    mode = m;
    pulse_start();
    budget = 0;
    while ((done_seen[0] == 0 || done_seen[1] == 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check($sformatf("campaign_m%0d_finished", m), 32'(budget < 200), 32'h1);
    repeat (3) @(negedge clk);
  endtask

  // Per-fault expectations: length, flag, order for one instance.
  task automatic check_results(input string tag, input int d,
                               input int exp_len [NF], input logic exp_flg [NF],
                               input int exp_cnt);
    check({tag, "_nvalid"}, 32'(nvalid[d]), 32'(NF));
    for (int f = 0; f < NF; f++) begin
      check($sformatf("%s_f%0d_idx", tag, f),  32'(fidx[d][f]), 32'(f));
      check($sformatf("%s_f%0d_flag", tag, f), 32'(flg[d][f]),  32'(exp_flg[f]));
      check($sformatf("%s_f%0d_len", tag, f),  32'(len[d][f]),  32'(exp_len[f]));
    end
    check({tag, "_cnt"},   32'(detected_cnt[d]), 32'(exp_cnt));
    check({tag, "_ndone"}, 32'(done_seen[d]),    32'h1);
  endtask

  initial begin
    int   budget;
    int   l8 [NF];
    int   l_ee [NF];
    logic f0 [NF];
    logic f2 [NF];
    logic f_first [NF];

    seq[0] = 16'hACE1;
    for (int i = 1; i < NV; i++) seq[i] = lfsr_step(seq[i-1]);
    for (int f = 0; f < NF; f++) begin
      l8[f] = NV; l_ee[f] = NV;
      f0[f] = 1'b0; f2[f] = 1'b0; f_first[f] = 1'b0;
    end
    l_ee[2] = 6; f2[2] = 1'b1; f_first[0] = 1'b1;
    for (int d = 0; d < 2; d++) busy_q[d] = 1'b0;
    clear_log();

    // Reset state
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;

    // No-fault equivalence, timing and LFSR determinism
    run_campaign(0);
    for (int d = 0; d < 2; d++) begin
      check_results($sformatf("nofault_d%0d", d), d, l8, f0, 0);
      check($sformatf("nofault_d%0d_done_delay", d), 32'(done_cyc[d] - arm_cyc[d]), 32'd40);
    end
    check("lfsr_f0_run0", 32'(v0[0][0]), 32'h0000ACE1);
    check("lfsr_f0_run1", 32'(v1[0][0]), 32'h00005670);
    check("lfsr_f3_run0", 32'(v0[0][3]), 32'h0000ACE1);
    check("lfsr_f3_run1", 32'(v1[0][3]), 32'h00005670);

    // Early exit vs full run, mismatch on fault 2 vector 5
    run_campaign(1);
    check_results("early", 0, l_ee, f2, 1);
    check_results("full",  1, l8,   f2, 1);

    // Mismatch on the last vector of fault 0
    run_campaign(2);
    check_results("lastvec_early", 0, l8, f_first, 1);
    check_results("lastvec_full",  1, l8, f_first, 1);

    // Abort during fault 1 RUN
    clear_log();
    mode = 0;
    pulse_start();
    budget = 0;
    while (!(fault_en[0] == 4'b0010 && run_cnt[0] >= 3) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("abort_reached_f1", 32'(budget < 100), 32'h1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_d%0d_busy", d),     32'(busy[d]),     32'h0);
      check($sformatf("abort_d%0d_fault_en", d), 32'(fault_en[d]), 32'h0);
    end
    repeat (60) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_d%0d_no_done", d), 32'(done_seen[d]),    32'h0);
      check($sformatf("abort_d%0d_nvalid", d),  32'(nvalid[d]),       32'h1);
      check($sformatf("abort_d%0d_cnt", d),     32'(detected_cnt[d]), 32'h0);
    end

    // Asynchronous reset during RUN
    clear_log();
    pulse_start();
    budget = 0;
    while (!(fault_en[0] == 4'b0001 && run_cnt[0] >= 3) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("rst_reached_run", 32'(budget < 100), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal campaign after reset
    run_campaign(1);
    check_results("post_rst_early", 0, l_ee, f2, 1);
    check_results("post_rst_full",  1, l8,   f2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
